// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and defaults for the two-requester register-bank arbiter.
package reg_bank_arbiter_pkg;

  localparam int unsigned DataWDefault    = 32;
  localparam int unsigned BurstMaxDefault = 4;
  localparam int unsigned CntW            = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrant0 = 2'b01,
    StGrant1 = 2'b10
  } state_e;

  typedef logic [CntW-1:0] cnt_t;

  // Burst count never exceeds max, so a lone requester cannot wrap it.
  function automatic cnt_t cnt_sat_inc(input cnt_t cnt, input cnt_t max);
    return (cnt >= max) ? max : cnt + cnt_t'(1);
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Request/grant/data bundle between the two masters and the arbiter.
interface reg_bank_arbiter_if
  import reg_bank_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
);

  logic              req0;
  logic              wr0;
  logic [1:0]        addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              wr1;
  logic [1:0]        addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req0, wr0, addr0, wdata0,
    output req1, wr1, addr1, wdata1,
    input  gnt0, gnt1, ack0, ack1, rdata
  );

  modport slave (
    input  req0, wr0, addr0, wdata0,
    input  req1, wr1, addr1, wdata1,
    output gnt0, gnt1, ack0, ack1, rdata
  );

endinterface

// File: rtl/reg_bank4.sv
// Four-entry register file: one synchronous write port, one combinational read port.
module reg_bank4 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        raddr_i,
  output logic [DATA_W-1:0] rq_o
);

  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rq_o = regs_q[raddr_i];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin, burst-limited arbiter giving two masters access to a shared four-register bank.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWDefault,
  parameter int unsigned BURST_MAX = BurstMaxDefault
) (
  input logic              clk,
  input logic              reset_n,
  reg_bank_arbiter_if.slave bus
);

  localparam cnt_t BurstMaxC = cnt_t'(BURST_MAX);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;      // 0: M0 wins a tie from idle, 1: M1 wins
  cnt_t              cnt_q, cnt_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              sel_m1;
  logic              cur_req;
  logic              oth_req;
  logic              cur_wr;
  logic [1:0]        cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] rq;
  logic              bank_we;
  cnt_t              cnt_inc;

  // Only the granted side's inputs reach the bank.
  always_comb begin
    sel_m1    = (state_q == StGrant1);
    cur_req   = sel_m1 ? bus.req1   : bus.req0;
    oth_req   = sel_m1 ? bus.req0   : bus.req1;
    cur_wr    = sel_m1 ? bus.wr1    : bus.wr0;
    cur_addr  = sel_m1 ? bus.addr1  : bus.addr0;
    cur_wdata = sel_m1 ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
    bank_we = 1'b0;
    cnt_inc = cnt_sat_inc(cnt_q, BurstMaxC);

    unique case (state_q)
      StIdle: begin
        if (bus.req0 && bus.req1) begin
          state_d = ptr_q ? StGrant1 : StGrant0;
        end else if (bus.req0) begin
          state_d = StGrant0;
        end else if (bus.req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        if (!cur_req) begin
          state_d = StIdle;
          ptr_d   = ~sel_m1;
          cnt_d   = '0;
        end else begin
          bank_we = cur_wr;
          if (!cur_wr) begin
            rdata_d = rq;
          end
          ack0_d = ~sel_m1;
          ack1_d = sel_m1;
          // Hand over straight to the waiting side once the burst limit is hit.
          if (oth_req && (cnt_inc == BurstMaxC)) begin
            state_d = sel_m1 ? StGrant0 : StGrant1;
            ptr_d   = sel_m1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
    end
  end

  reg_bank4 #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (bank_we),
    .waddr_i (cur_addr),
    .wdata_i (cur_wdata),
    .raddr_i (cur_addr),
    .rq_o    (rq)
  );

  assign bus.gnt0  = (state_q == StGrant0);
  assign bus.gnt1  = (state_q == StGrant1);
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed scoreboard bench for reg_bank_arbiter: expected acks are queued, a monitor pops them.
module tb_reg_bank_arbiter;

  typedef struct packed {
    logic        side;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t exp_q [$];
  int   n_chk;
  int   n_fail;

  reg_bank_arbiter_if #(.DATA_W(32)) bus ();

  reg_bank_arbiter #(
    .DATA_W    (32),
    .BURST_MAX (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic side, input logic chk_rd, input logic [31:0] rd);
    exp_t e;
    e.side   = side;
    e.chk_rd = chk_rd;
    e.rd     = rd;
    exp_q.push_back(e);
  endtask

  task automatic chk_gnt(input string nm, input logic g0, input logic g1);
    chk({nm, "_gnt0"}, {31'd0, bus.gnt0}, {31'd0, g0});
    chk({nm, "_gnt1"}, {31'd0, bus.gnt1}, {31'd0, g1});
  endtask

  task automatic chk_all_zero(input string nm);
    chk_gnt(nm, 1'b0, 1'b0);
    chk({nm, "_ack0"}, {31'd0, bus.ack0}, 32'd0);
    chk({nm, "_ack1"}, {31'd0, bus.ack1}, 32'd0);
    chk({nm, "_rdata"}, bus.rdata, 32'd0);
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      if (bus.ack0 && bus.ack1) begin
        n_chk++;
        n_fail++;
        $display("FAIL dual_ack: got ack0=1 ack1=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack1=%0b with no transaction expected", bus.ack1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_side", {31'd0, bus.ack1}, {31'd0, e.side});
        if (e.chk_rd) begin
          chk("rdata", bus.rdata, e.rd);
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n    = 1'b0;
    bus.req0   = 1'b0;
    bus.wr0    = 1'b0;
    bus.addr0  = 2'd0;
    bus.wdata0 = '0;
    bus.req1   = 1'b0;
    bus.wr1    = 1'b0;
    bus.addr1  = 2'd0;
    bus.wdata1 = '0;

    // Reset then idle.
    step();
    step();
    reset_n = 1'b1;
    repeat (5) step();
    chk_all_zero("idle");

    // Single master: write then read back.
    bus.req0   = 1'b1;
    bus.wr0    = 1'b1;
    bus.addr0  = 2'd2;
    bus.wdata0 = 32'hDEADBEEF;
    chk_gnt("pre_gnt", 1'b0, 1'b0);
    step();
    chk_gnt("gnt_lat", 1'b1, 1'b0);
    push(1'b0, 1'b0, '0);
    step();
    bus.wr0 = 1'b0;
    push(1'b0, 1'b1, 32'hDEADBEEF);
    step();
    bus.req0 = 1'b0;
    step();
    chk_gnt("single_drop", 1'b0, 1'b0);

    // Simultaneous request straight after reset: M0 first, M1 via idle.
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    bus.req0   = 1'b1;
    bus.wr0    = 1'b1;
    bus.addr0  = 2'd1;
    bus.wdata0 = 32'h11111111;
    bus.req1   = 1'b1;
    bus.wr1    = 1'b1;
    bus.addr1  = 2'd3;
    bus.wdata1 = 32'h33333333;
    step();
    chk_gnt("tie", 1'b1, 1'b0);
    push(1'b0, 1'b0, '0);
    step();
    bus.wr0 = 1'b0;
    push(1'b0, 1'b1, 32'h11111111);
    step();
    bus.req0 = 1'b0;
    step();
    chk_gnt("tie_idle", 1'b0, 1'b0);
    step();
    chk_gnt("tie_m1", 1'b0, 1'b1);
    push(1'b1, 1'b0, '0);
    step();
    bus.wr1 = 1'b0;
    push(1'b1, 1'b1, 32'h33333333);
    step();
    bus.req1 = 1'b0;
    step();

    // Burst fairness: both requesting, alternating groups of four.
    bus.req0  = 1'b1;
    bus.wr0   = 1'b0;
    bus.addr0 = 2'd1;
    bus.req1  = 1'b1;
    bus.wr1   = 1'b0;
    bus.addr1 = 2'd3;
    step();
    for (int k = 0; k < 12; k++) begin
      logic side;
      side = logic'((k / 4) % 2);
      chk_gnt($sformatf("burst%0d", k), ~side, side);
      push(side, 1'b1, side ? 32'h33333333 : 32'h11111111);
      step();
    end
    chk_gnt("burst_end", 1'b0, 1'b1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    chk_gnt("burst_idle", 1'b0, 1'b0);

    // Waiting side's write must not land while the other side is granted.
    bus.req0   = 1'b1;
    bus.wr0    = 1'b0;
    bus.addr0  = 2'd0;
    bus.req1   = 1'b1;
    bus.wr1    = 1'b1;
    bus.addr1  = 2'd0;
    bus.wdata1 = 32'h12345678;
    step();
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 1'b1, 32'h0);
      step();
    end
    chk_gnt("ign_m1", 1'b0, 1'b1);
    push(1'b1, 1'b0, '0);
    step();
    bus.req1 = 1'b0;
    step();
    chk_gnt("ign_idle", 1'b0, 1'b0);
    step();
    chk_gnt("ign_m0", 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h12345678);
    step();
    bus.req0 = 1'b0;
    step();

    // Reset during M1's second transaction.
    bus.req1   = 1'b1;
    bus.wr1    = 1'b1;
    bus.addr1  = 2'd2;
    bus.wdata1 = 32'hAAAA0001;
    step();
    chk_gnt("rst_m1", 1'b0, 1'b1);
    push(1'b1, 1'b0, '0);
    step();
    bus.addr1  = 2'd1;
    bus.wdata1 = 32'hBBBB0002;
    reset_n    = 1'b0;
    step();
    chk_all_zero("mid_rst");
    step();
    reset_n   = 1'b1;
    bus.req0  = 1'b1;
    bus.wr0   = 1'b0;
    bus.addr0 = 2'd1;
    step();
    chk_gnt("rst_ptr", 1'b1, 1'b0);
    push(1'b0, 1'b1, 32'h0);
    step();
    bus.addr0 = 2'd2;
    push(1'b0, 1'b1, 32'h0);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) step();

    chk("pending_acks", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
